// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ramp
//  Description : Slews the PWM duty word toward an accepted target in fixed
//                steps, changing it only at PWM period boundaries.
//                Optional DUTY_RAMP_RETARGET_EN: accept new targets mid-ramp.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_duty_ramp #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt_duty,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] duty,
    output logic             ramp_busy,
    output logic             period_tick
);

    localparam int                 c_div_w    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
    localparam logic [WIDTH:0]     c_step     = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [WIDTH-1:0]     r_cnt_q,   w_cnt_d;
    logic [c_div_w-1:0]   r_div_q,   w_div_d;
    logic [WIDTH-1:0]     r_tgt_q,   w_tgt_d;
    logic [WIDTH-1:0]     r_duty_q,  w_duty_d;

    logic                 w_accept;
    logic [WIDTH:0]       w_up_sum;
    logic [WIDTH:0]       w_down_gap;
    logic [WIDTH-1:0]     w_step_duty;

    assign period_tick = (&r_cnt_q) && !rst;
    assign ramp_busy   = (r_state_q != ST_IDLE) && !rst;
    assign duty        = r_duty_q;
`ifdef DUTY_RAMP_RETARGET_EN
    assign tgt_ready   = !rst;
`else
    assign tgt_ready   = (r_state_q == ST_IDLE) && !rst;
`endif
    assign w_accept    = tgt_valid && tgt_ready;

    // One extra bit keeps the clamp compares free of wrap-around.
    always_comb begin
        w_up_sum    = {1'b0, r_duty_q} + c_step;
        w_down_gap  = {1'b0, r_duty_q} - {1'b0, r_tgt_q};
        w_step_duty = r_duty_q;
        case (r_state_q)
            ST_UP: begin
                if (w_up_sum >= {1'b0, r_tgt_q}) begin
                    w_step_duty = r_tgt_q;
                end else begin
                    w_step_duty = w_up_sum[WIDTH-1:0];
                end
            end
            ST_DOWN: begin
                if (w_down_gap <= c_step) begin
                    w_step_duty = r_tgt_q;
                end else begin
                    w_step_duty = r_duty_q - c_step[WIDTH-1:0];
                end
            end
            default: w_step_duty = r_duty_q;
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q + 1'b1;
        w_div_d   = r_div_q;
        w_tgt_d   = r_tgt_q;
        w_duty_d  = r_duty_q;
        if (w_accept) begin
            // Acceptance takes priority over a coincident period boundary.
            w_tgt_d = tgt_duty;
            w_div_d = '0;
            if (tgt_duty > r_duty_q) begin
                w_state_d = ST_UP;
            end else if (tgt_duty < r_duty_q) begin
                w_state_d = ST_DOWN;
            end else begin
                w_state_d = ST_IDLE;
            end
        end else if ((r_state_q != ST_IDLE) && period_tick) begin
            if (r_div_q == c_div_last) begin
                w_div_d  = '0;
                w_duty_d = w_step_duty;
                if (w_step_duty == r_tgt_q) begin
                    w_state_d = ST_IDLE;
                end
            end else begin
                w_div_d = r_div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_div_q   <= '0;
            r_tgt_q   <= '0;
            r_duty_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_div_q   <= w_div_d;
            r_tgt_q   <= w_tgt_d;
            r_duty_q  <= w_duty_d;
        end
    end

endmodule
`default_nettype wire
